// File: rtl/div_pkg.sv
// Shared types for the divider arbiter: FSM states, error codes and the response bundle.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_DIVZERO = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_t;

    localparam int RSP_WIDTH = 32;
    localparam int RSP_ID_W  = 2;

    // Response bundle in the default configuration (4 requesters, 32-bit operands).
    typedef struct packed {
        logic [RSP_ID_W-1:0]  id;
        logic [RSP_WIDTH-1:0] quotient;
        logic [RSP_WIDTH-1:0] remainder;
        err_t                 err;
    } div_rsp_t;

endpackage

// File: rtl/div_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic found;
        int   cand;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one sequential divider among NUM_REQ requesters: round-robin grant,
// local divide-by-zero handling, watchdog on the divider and one tagged response at a time.
module div_arbiter
    import div_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_dividend,
    input  logic [NUM_REQ*WIDTH-1:0]   req_divisor,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_quotient,
    output logic [WIDTH-1:0]           rsp_remainder,
    output logic [1:0]                 rsp_err,
    output logic                       busy,
    output logic                       div_start,
    output logic [WIDTH-1:0]           div_dividend,
    output logic [WIDTH-1:0]           div_divisor,
    input  logic                       div_done,
    input  logic [WIDTH-1:0]           div_quotient,
    input  logic [WIDTH-1:0]           div_remainder
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WIDTH-1:0]  dvd_q, dvd_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    err_t              err_q, err_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic [WIDTH-1:0]   sel_dvd;
    logic [WIDTH-1:0]   sel_dvs;
    logic               handshake;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        return (v == ID_W'(NUM_REQ - 1)) ? '0 : v + 1'b1;
    endfunction

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign sel_dvd   = req_dividend[gnt_idx*WIDTH +: WIDTH];
    assign sel_dvs   = req_divisor[gnt_idx*WIDTH +: WIDTH];
    assign handshake = (state_q == IDLE) && (|gnt);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    id_d  = gnt_idx;
                    ptr_d = wrap_inc(gnt_idx);
                    dvd_d = sel_dvd;
                    dvs_d = sel_dvs;
                    // Divide-by-zero never reaches the divider.
                    if (sel_dvs == '0) begin
                        quo_d   = '1;
                        rem_d   = sel_dvd;
                        err_d   = ERR_DIVZERO;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A done arriving on the last watchdog cycle still counts as success.
                if (div_done) begin
                    quo_d   = div_quotient;
                    rem_d   = div_remainder;
                    err_d   = ERR_OK;
                    state_d = RESP;
                end else if (cnt_q == CNT_MAX) begin
                    quo_d   = '0;
                    rem_d   = '0;
                    err_d   = ERR_TIMEOUT;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    // Grant is masked while reset is held so no requester sees a ready it cannot use.
    assign req_ready     = (reset && state_q == IDLE) ? gnt : '0;
    assign busy          = (state_q != IDLE);
    assign div_start     = (state_q == ISSUE);
    assign div_dividend  = dvd_q;
    assign div_divisor   = dvs_q;
    assign rsp_valid     = (state_q == RESP);
    assign rsp_id        = id_q;
    assign rsp_quotient  = quo_q;
    assign rsp_remainder = rem_q;
    assign rsp_err       = err_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter; the bench plays the divider with hand-computed results.
module tb_div_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*W-1:0]   req_dividend;
    logic [NR*W-1:0]   req_divisor;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_quotient;
    logic [W-1:0]      rsp_remainder;
    logic [1:0]        rsp_err;
    logic              busy;
    logic              div_start;
    logic [W-1:0]      div_dividend;
    logic [W-1:0]      div_divisor;
    logic              div_done;
    logic [W-1:0]      div_quotient;
    logic [W-1:0]      div_remainder;

    int n_total = 0;
    int n_pass  = 0;

    div_arbiter #(
        .NUM_REQ (NR),
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]           = 1'b1;
        req_dividend[i*W +: W] = a;
        req_divisor[i*W +: W]  = b;
    endtask

    // Grant check, launch, divider reply after lat WAIT cycles, response check and accept.
    task automatic serve(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input int lat);
        #1;
        chk("grant", 32'(req_ready), 32'(1 << id));
        step();
        chk("start_hi", 32'(div_start), 32'd1);
        chk("div_dividend", div_dividend, a);
        chk("div_divisor", div_divisor, b);
        chk("ready_busy", 32'(req_ready), 32'd0);
        step();
        chk("start_lo", 32'(div_start), 32'd0);
        repeat (lat) step();
        div_done      = 1'b1;
        div_quotient  = q;
        div_remainder = r;
        step();
        div_done      = 1'b0;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_q", rsp_quotient, q);
        chk("rsp_r", rsp_remainder, r);
        chk("rsp_err", 32'(rsp_err), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        reset         = 1'b0;
        req_valid     = '1;
        req_dividend  = '0;
        req_divisor   = '0;
        rsp_ready     = 1'b0;
        div_done      = 1'b0;
        div_quotient  = '0;
        div_remainder = '0;
        step();
        step();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_start", 32'(div_start), 32'd0);
        chk("rst_dividend", div_dividend, 32'd0);
        chk("rst_rsp_q", rsp_quotient, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        req_valid = '0;
        reset     = 1'b1;
        step();

        // Basic divides from requester 0
        set_req(0, 32'd10, 32'd3);
        serve(0, 32'd10, 32'd3, 32'd3, 32'd1, 3);
        req_valid = '0;
        set_req(0, 32'd30, 32'd4);
        serve(0, 32'd30, 32'd4, 32'd7, 32'd2, 1);
        req_valid = '0;

        // Two requesters held valid alternate
        set_req(1, 32'd20, 32'd6);
        set_req(2, 32'd9, 32'd2);
        serve(1, 32'd20, 32'd6, 32'd3, 32'd2, 0);
        serve(2, 32'd9, 32'd2, 32'd4, 32'd1, 2);
        serve(1, 32'd20, 32'd6, 32'd3, 32'd2, 1);
        serve(2, 32'd9, 32'd2, 32'd4, 32'd1, 0);
        req_valid = '0;
        set_req(3, 32'd11, 32'd2);
        serve(3, 32'd11, 32'd2, 32'd5, 32'd1, 1);
        req_valid = '0;
        set_req(1, 32'd13, 32'd3);
        set_req(3, 32'd6, 32'd6);
        serve(1, 32'd13, 32'd3, 32'd4, 32'd1, 1);
        req_valid = '0;

        // Divide-by-zero from requester 3
        set_req(3, 32'd7, 32'd0);
        #1;
        chk("dz_grant", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        chk("dz_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("dz_start", 32'(div_start), 32'd0);
        chk("dz_q", rsp_quotient, 32'hFFFF_FFFF);
        chk("dz_r", rsp_remainder, 32'd7);
        chk("dz_err", 32'(rsp_err), 32'd1);
        chk("dz_id", 32'(rsp_id), 32'd3);
        step();
        chk("dz_start_hold", 32'(div_start), 32'd0);
        chk("dz_rsp_hold", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("dz_rsp_drop", 32'(rsp_valid), 32'd0);

        // Watchdog timeout, then a stray done in IDLE
        set_req(0, 32'd5, 32'd1);
        #1;
        chk("to_grant", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        chk("to_start", 32'(div_start), 32'd1);
        step();
        repeat (TO - 1) step();
        chk("to_early", 32'(rsp_valid), 32'd0);
        chk("to_busy", 32'(busy), 32'd1);
        step();
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_err", 32'(rsp_err), 32'd2);
        chk("to_q", rsp_quotient, 32'd0);
        chk("to_r", rsp_remainder, 32'd0);
        chk("to_id", 32'(rsp_id), 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready     = 1'b0;
        div_done      = 1'b1;
        div_quotient  = 32'd123;
        div_remainder = 32'd45;
        step();
        div_done = 1'b0;
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("stray_start", 32'(div_start), 32'd0);
        chk("stray_q", rsp_quotient, 32'd0);
        chk("stray_err", 32'(rsp_err), 32'd2);

        // Response back-pressure with a pending request
        set_req(1, 32'd50, 32'd7);
        #1;
        chk("bp_grant", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        step();
        div_done      = 1'b1;
        div_quotient  = 32'd7;
        div_remainder = 32'd1;
        step();
        div_done = 1'b0;
        set_req(0, 32'd8, 32'd2);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_q", rsp_quotient, 32'd7);
            chk("bp_r", rsp_remainder, 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd1);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_ready_accept", 32'(req_ready), 32'd0);
        step();
        rsp_ready = 1'b0;
        chk("bp_idle", 32'(busy), 32'd0);
        serve(0, 32'd8, 32'd2, 32'd4, 32'd0, 1);
        req_valid = '0;

        // Reset in WAIT drops the transaction
        set_req(2, 32'd1, 32'd1);
        #1;
        chk("rw_grant", 32'(req_ready), 32'b0100);
        step();
        step();
        step();
        reset = 1'b0;
        step();
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rw_start", 32'(div_start), 32'd0);
        chk("rw_ready", 32'(req_ready), 32'd0);
        chk("rw_dividend", div_dividend, 32'd0);
        chk("rw_divisor", div_divisor, 32'd0);
        chk("rw_rsp_q", rsp_quotient, 32'd0);
        chk("rw_rsp_id", 32'(rsp_id), 32'd0);
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rw_no_rsp", 32'(rsp_valid), 32'd0);
            chk("rw_idle", 32'(busy), 32'd0);
        end
        rsp_ready = 1'b0;
        set_req(2, 32'd100, 32'd5);
        serve(2, 32'd100, 32'd5, 32'd20, 32'd0, 2);
        req_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
